// File: rtl/mix_col_seq_if.sv
// mix_col_seq_if: input and output handshake bundle for the column-serial MixColumns sequencer.
interface mix_col_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         bypass_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;
    modport slave (input in_valid, state_in, bypass_in, out_ready, output in_ready, out_valid, state_out, busy);
    modport master (output in_valid, state_in, bypass_in, out_ready, input in_ready, out_valid, state_out, busy);
endinterface

// File: rtl/mix_col_seq.sv
// mix_col_seq: iterative AES MixColumns over a 128-bit working register, COLS_PER_CYCLE columns per cycle.
module mix_col (
    input  logic [31:0] a,
    output logic [31:0] y
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = a;
    assign y = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
endmodule

module mix_col_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input logic         clk,
    input logic         rst,
    mix_col_seq_if.slave bus
);
    localparam int RUN_CYCLES = 4 / COLS_PER_CYCLE;
    localparam int CW = RUN_CYCLES > 1 ? $clog2(RUN_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;
    st_t           st;
    logic [CW-1:0] cnt;
    logic [127:0]  work;
    logic [1:0]    sel   [COLS_PER_CYCLE];
    logic [31:0]   mixed [COLS_PER_CYCLE];
    // column c lives at work[127-32c -: 32], so column index maps to slice 3-c
    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_mix
        assign sel[k] = 2'(int'(cnt) * COLS_PER_CYCLE + k);
        mix_col u_mix (.a(work[(3 - int'(sel[k])) * 32 +: 32]), .y(mixed[k]));
    end
    assign bus.in_ready  = st == IDLE;
    assign bus.out_valid = st == DONE;
    assign bus.busy      = st != IDLE;
    assign bus.state_out = work;
    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= IDLE;
            cnt  <= '0;
            work <= '0;
        end else begin
            case (st)
                IDLE: if (bus.in_valid) begin
                    work <= bus.state_in;
                    cnt  <= '0;
                    st   <= bus.bypass_in ? DONE : RUN;
                end
                RUN: begin
                    for (int i = 0; i < COLS_PER_CYCLE; i++) work[(3 - int'(sel[i])) * 32 +: 32] <= mixed[i];
                    cnt <= cnt == CW'(RUN_CYCLES - 1) ? '0 : cnt + 1'b1;
                    if (cnt == CW'(RUN_CYCLES - 1)) st <= DONE;
                end
                DONE: if (bus.out_ready) st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mix_col_seq.sv
// tb_mix_col_seq: directed FIPS-197 vectors against COLS_PER_CYCLE=1 and =2 instances sharing one stimulus.
module tb_mix_col_seq;
    logic         clk = 0;
    logic         rst = 1;
    logic         in_valid = 0;
    logic         bypass = 0;
    logic         out_ready = 0;
    logic         sel = 0;
    logic [127:0] state_in = '0;
    int           n_tests = 0;
    int           n_fail = 0;
    mix_col_seq_if b1 ();
    mix_col_seq_if b2 ();
    mix_col_seq #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    mix_col_seq #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
    assign b1.in_valid  = in_valid & ~sel;
    assign b2.in_valid  = in_valid & sel;
    assign b1.out_ready = out_ready & ~sel;
    assign b2.out_ready = out_ready & sel;
    assign b1.state_in  = state_in;
    assign b2.state_in  = state_in;
    assign b1.bypass_in = bypass;
    assign b2.bypass_in = bypass;
    wire         ir   = sel ? b2.in_ready  : b1.in_ready;
    wire         ov   = sel ? b2.out_valid : b1.out_valid;
    wire         bz   = sel ? b2.busy      : b1.busy;
    wire [127:0] so   = sel ? b2.state_out : b1.state_out;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [127:0] s, input logic b);
        int n = 0;
        state_in = s;
        bypass   = b;
        in_valid = 1;
        while (!ir && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("send_timeout", 0, 1);
        tick();
        in_valid = 0;
    endtask
    task automatic wait_out(output int n);
        n = 0;
        while (!ov && n < 50) begin
            tick();
            n++;
        end
    endtask
    localparam logic [127:0] V1  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] E1  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V2  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] E2  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] V3  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] E3  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    initial begin
        int lat, bad;
        int ta [3];
        int to [3];
        logic [127:0] v [3];
        logic [127:0] e [3];
        in_valid = 1;
        state_in = V1;
        tick();
        tick();
        in_valid = 0;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #0;
            check($sformatf("rst_in_ready%0d", s), 128'(ir), 1);
            check($sformatf("rst_out_valid%0d", s), 128'(ov), 0);
            check($sformatf("rst_busy%0d", s), 128'(bz), 0);
            check($sformatf("rst_state_out%0d", s), so, 0);
        end
        rst = 0;
        sel = 0;
        tick();
        check("idle_after_rst", 128'(ir), 1);
        out_ready = 1;
        send(V1, 0);
        wait_out(lat);
        check("fips_lat", lat, 4);
        check("fips_state", so, E1);
        tick();
        check("fips_ov_pulse", 128'(ov), 0);
        check("fips_ready_back", 128'(ir), 1);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            out_ready = 0;
            send(V2, 0);
            wait_out(lat);
            check($sformatf("r1_lat%0d", s), lat, s ? 2 : 4);
            bad = 0;
            for (int i = 0; i < 5; i++) begin
                if (so !== E2 || !ov || ir) bad++;
                tick();
            end
            check($sformatf("r1_stable%0d", s), bad, 0);
            check($sformatf("r1_state%0d", s), so, E2);
            out_ready = 1;
            tick();
            out_ready = 0;
            check($sformatf("r1_ready_back%0d", s), 128'(ir), 1);
            check($sformatf("r1_ov_drop%0d", s), 128'(ov), 0);
        end
        sel = 0;
        out_ready = 1;
        send(V3, 1);
        check("byp_ov_next_cycle", 128'(ov), 1);
        check("byp_state", so, V3);
        tick();
        send(V3, 0);
        wait_out(lat);
        check("nobyp_lat", lat, 4);
        check("nobyp_state", so, E3);
        tick();
        send(V2, 0);
        tick();
        rst = 1;
        tick();
        rst = 0;
        check("midrst_in_ready", 128'(ir), 1);
        check("midrst_busy", 128'(bz), 0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (ov) bad++;
            tick();
        end
        check("midrst_no_ov", bad, 0);
        send(V2, 0);
        wait_out(lat);
        check("midrst_next_state", so, E2);
        tick();
        v = '{V1, V2, V3};
        e = '{E1, E2, E3};
        begin
            int ki = 0, ko = 0, cyc = 0;
            logic acc;
            bad = 0;
            state_in = v[0];
            bypass = 0;
            in_valid = 1;
            while (ko < 3 && cyc < 60) begin
                acc = ir & in_valid;
                tick();
                cyc++;
                if (acc) begin
                    ta[ki] = cyc;
                    ki++;
                    if (ki < 3) state_in = v[ki];
                    else in_valid = 0;
                end
                if (ov) begin
                    check($sformatf("stream_state%0d", ko), so, e[ko]);
                    to[ko] = cyc;
                    ko++;
                end
                if (ir == bz) bad++;
            end
            in_valid = 0;
            check("stream_count", ko, 3);
            check("stream_ready_vs_busy", bad, 0);
            check("stream_in_period", ta[1] - ta[0], 6);
            check("stream_out_period01", to[1] - to[0], 6);
            check("stream_out_period12", to[2] - to[1], 6);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
